// File: rtl/screen_writer_pkg.sv
// Shared constants, types and helpers for the LT24 Snake screen writer.
// Covers panel geometry, RGB565 colours, controller opcodes and the command ROMs.
package screen_writer_pkg;

   localparam int LCD_W = 240;
   localparam int LCD_H = 320;

   localparam logic [15:0] COL_BG    = 16'h0000;
   localparam logic [15:0] COL_APPLE = 16'hF800;
   localparam logic [15:0] COL_HEAD  = 16'hFFE0;
   localparam logic [15:0] COL_BODY  = 16'h07E0;

   localparam logic [15:0] CMD_SLPOUT = 16'h0011;
   localparam logic [15:0] CMD_COLMOD = 16'h003A;
   localparam logic [15:0] CMD_MADCTL = 16'h0036;
   localparam logic [15:0] CMD_DISPON = 16'h0029;
   localparam logic [15:0] CMD_CASET  = 16'h002A;
   localparam logic [15:0] CMD_PASET  = 16'h002B;
   localparam logic [15:0] CMD_RAMWR  = 16'h002C;

   localparam logic [15:0] COLMOD_16BPP = 16'h0055;
   localparam logic [15:0] MADCTL_BGR   = 16'h0008;

   localparam int INIT_LAST  = 5;
   localparam int SETUP_LAST = 10;

   typedef enum logic [2:0] {
      RST_LOW,
      RST_WAIT,
      INIT,
      FRAME_SETUP,
      PIXELS
   } state_e;

   typedef struct packed {
      logic        rs;
      logic [15:0] data;
   } lcd_word_t;

   // Step 0 (sleep out) is followed by a settle wait handled by the FSM.
   function automatic lcd_word_t init_word(input logic [3:0] idx);
      lcd_word_t w;
      case (idx)
         4'd0:    w = '{rs: 1'b0, data: CMD_SLPOUT};
         4'd1:    w = '{rs: 1'b0, data: CMD_COLMOD};
         4'd2:    w = '{rs: 1'b1, data: COLMOD_16BPP};
         4'd3:    w = '{rs: 1'b0, data: CMD_MADCTL};
         4'd4:    w = '{rs: 1'b1, data: MADCTL_BGR};
         default: w = '{rs: 1'b0, data: CMD_DISPON};
      endcase
      return w;
   endfunction

   function automatic lcd_word_t setup_word(input logic [3:0]  idx,
                                            input logic [15:0] x_end,
                                            input logic [15:0] y_end);
      lcd_word_t w;
      case (idx)
         4'd0:    w = '{rs: 1'b0, data: CMD_CASET};
         4'd3:    w = '{rs: 1'b1, data: {8'h00, x_end[15:8]}};
         4'd4:    w = '{rs: 1'b1, data: {8'h00, x_end[7:0]}};
         4'd5:    w = '{rs: 1'b0, data: CMD_PASET};
         4'd8:    w = '{rs: 1'b1, data: {8'h00, y_end[15:8]}};
         4'd9:    w = '{rs: 1'b1, data: {8'h00, y_end[7:0]}};
         4'd10:   w = '{rs: 1'b0, data: CMD_RAMWR};
         default: w = '{rs: 1'b1, data: 16'h0000};
      endcase
      return w;
   endfunction

   // Ten-bit operands keep x + size from wrapping near the panel edge.
   function automatic logic in_block(input logic [9:0] px, input logic [9:0] py,
                                     input logic [9:0] x,  input logic [9:0] y,
                                     input logic [9:0] size);
      return (px >= x) && (px < x + size) && (py >= y) && (py < y + size);
   endfunction

endpackage

// File: rtl/screen_writer_if.sv
// LT24 8080-style parallel write bus between the screen writer and the panel pins.
interface screen_writer_if;
   logic        LT24Wr_n;
   logic        LT24Rd_n;
   logic        LT24CS_n;
   logic        LT24RS;
   logic        LT24Reset_n;
   logic [15:0] LT24Data;
   logic        LT24LCDOn;

   modport master (
      output LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS, LT24Reset_n, LT24Data, LT24LCDOn
   );

   modport slave (
      input LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS, LT24Reset_n, LT24Data, LT24LCDOn
   );
endinterface

// File: rtl/screen_writer_word_writer.sv
// Two-clock LT24 write: strobe low with RS/data valid, then strobe high with them held.
// Chip select drops on the first word and stays low until reset.
module lt24_word_writer
   import screen_writer_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        valid,
   input  lcd_word_t   word,
   output logic        ready,
   output logic        wr_n,
   output logic        cs_n,
   output logic        rs,
   output logic [15:0] data
);

   logic        phase_a_q, phase_a_d;
   logic        wr_n_q, wr_n_d;
   logic        cs_n_q, cs_n_d;
   logic        rs_q, rs_d;
   logic [15:0] data_q, data_d;

   always_comb begin
      phase_a_d = phase_a_q;
      wr_n_d    = wr_n_q;
      cs_n_d    = cs_n_q;
      rs_d      = rs_q;
      data_d    = data_q;
      if (phase_a_q) begin
         phase_a_d = 1'b0;
         wr_n_d    = 1'b1;
      end else if (valid) begin
         phase_a_d = 1'b1;
         wr_n_d    = 1'b0;
         cs_n_d    = 1'b0;
         rs_d      = word.rs;
         data_d    = word.data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         phase_a_q <= 1'b0;
         wr_n_q    <= 1'b1;
         cs_n_q    <= 1'b1;
         rs_q      <= 1'b1;
         data_q    <= 16'h0000;
      end else begin
         phase_a_q <= phase_a_d;
         wr_n_q    <= wr_n_d;
         cs_n_q    <= cs_n_d;
         rs_q      <= rs_d;
         data_q    <= data_d;
      end
   end

   assign ready = ~phase_a_q;
   assign wr_n  = wr_n_q;
   assign cs_n  = cs_n_q;
   assign rs    = rs_q;
   assign data  = data_q;

endmodule

// File: rtl/screen_writer.sv
// Streams Snake frames to the LT24: power-up/init sequence, then endless window setup
// plus raster pixel bursts, with game coordinates frozen for the duration of each frame.
module screen_writer
   import screen_writer_pkg::*;
#(
   parameter int CLK_HZ          = 50_000_000,
   parameter int BLOCK           = 10,
   parameter int NSEG            = 128,
   parameter int RST_LOW_CYCLES  = 500,
   parameter int RST_WAIT_CYCLES = 250_000,
   parameter int H_RES           = LCD_W,
   parameter int V_RES           = LCD_H
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [7:0]          appleX,
   input  logic [8:0]          appleY,
   input  logic [8*NSEG-1:0]   snakeX,
   input  logic [9*NSEG-1:0]   snakeY,
   screen_writer_if.master     lcd
);

   localparam logic [15:0] X_END     = 16'(H_RES - 1);
   localparam logic [15:0] Y_END     = 16'(V_RES - 1);
   localparam logic [7:0]  PX_LAST   = 8'(H_RES - 1);
   localparam logic [8:0]  PY_LAST   = 9'(V_RES - 1);
   localparam logic [31:0] LOW_LAST  = 32'(RST_LOW_CYCLES - 1);
   localparam logic [31:0] WAIT_LAST = 32'(RST_WAIT_CYCLES - 1);

   logic unused_clk_hz;
   assign unused_clk_hz = ^CLK_HZ;

   state_e              state_q, state_d;
   logic [31:0]         cnt_q, cnt_d;
   logic [3:0]          step_q, step_d;
   logic                slp_wait_q, slp_wait_d;
   logic                reset_n_q, reset_n_d;
   logic                lcd_on_q, lcd_on_d;
   logic [7:0]          px_q, px_d;
   logic [8:0]          py_q, py_d;
   logic [15:0]         col_q, col_d;
   logic [7:0]          apple_x_q, apple_x_d;
   logic [8:0]          apple_y_q, apple_y_d;
   logic [8*NSEG-1:0]   snake_x_q, snake_x_d;
   logic [9*NSEG-1:0]   snake_y_q, snake_y_d;

   logic                latch_en;
   logic                wr_valid;
   logic                wr_ready;
   lcd_word_t           wr_word;

   logic [9:0]          px_w, py_w, seg_x, seg_y;
   logic [NSEG-1:0]     seg_hit;
   logic                apple_hit;

   assign px_w = {2'b00, px_q};
   assign py_w = {1'b0, py_q};

   // Colour of the pixel under the scan counters; registered so it is ready one cycle early.
   always_comb begin
      seg_hit = '0;
      seg_x   = '0;
      seg_y   = '0;
      for (int i = 0; i < NSEG; i++) begin
         seg_x      = {2'b00, snake_x_q[8*i +: 8]};
         seg_y      = {1'b0, snake_y_q[9*i +: 9]};
         seg_hit[i] = ((seg_x != 10'd0) || (seg_y != 10'd0)) &&
                      in_block(px_w, py_w, seg_x, seg_y, 10'(BLOCK));
      end
      apple_hit = in_block(px_w, py_w, {2'b00, apple_x_q}, {1'b0, apple_y_q}, 10'(BLOCK));
      if (apple_hit)       col_d = COL_APPLE;
      else if (seg_hit[0]) col_d = COL_HEAD;
      else if (|seg_hit)   col_d = COL_BODY;
      else                 col_d = COL_BG;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      step_d     = step_q;
      slp_wait_d = slp_wait_q;
      reset_n_d  = reset_n_q;
      lcd_on_d   = lcd_on_q;
      px_d       = px_q;
      py_d       = py_q;
      latch_en   = 1'b0;
      wr_valid   = 1'b0;
      wr_word    = '0;
      case (state_q)
         RST_LOW: begin
            if (cnt_q == LOW_LAST) begin
               state_d   = RST_WAIT;
               cnt_d     = '0;
               reset_n_d = 1'b1;
               lcd_on_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         RST_WAIT: begin
            if (cnt_q == WAIT_LAST) begin
               state_d = INIT;
               cnt_d   = '0;
               step_d  = '0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         INIT: begin
            if (slp_wait_q) begin
               if (cnt_q == WAIT_LAST) begin
                  slp_wait_d = 1'b0;
                  cnt_d      = '0;
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
            end else begin
               wr_valid = 1'b1;
               wr_word  = init_word(step_q);
               if (wr_ready) begin
                  if (step_q == 4'd0) begin
                     slp_wait_d = 1'b1;
                     cnt_d      = '0;
                  end
                  if (step_q == 4'(INIT_LAST)) begin
                     state_d  = FRAME_SETUP;
                     step_d   = '0;
                     latch_en = 1'b1;
                  end else begin
                     step_d = step_q + 4'd1;
                  end
               end
            end
         end
         FRAME_SETUP: begin
            wr_valid = 1'b1;
            wr_word  = setup_word(step_q, X_END, Y_END);
            if (wr_ready) begin
               if (step_q == 4'(SETUP_LAST)) begin
                  state_d = PIXELS;
                  step_d  = '0;
                  px_d    = '0;
                  py_d    = '0;
               end else begin
                  step_d = step_q + 4'd1;
               end
            end
         end
         PIXELS: begin
            wr_valid = 1'b1;
            wr_word  = '{rs: 1'b1, data: col_q};
            if (wr_ready) begin
               if (px_q == PX_LAST) begin
                  px_d = '0;
                  if (py_q == PY_LAST) begin
                     py_d     = '0;
                     state_d  = FRAME_SETUP;
                     latch_en = 1'b1;
                  end else begin
                     py_d = py_q + 9'd1;
                  end
               end else begin
                  px_d = px_q + 8'd1;
               end
            end
         end
         default: state_d = RST_LOW;
      endcase
   end

   // Coordinates are captured only on entry to frame setup, so a frame never tears.
   assign apple_x_d = latch_en ? appleX : apple_x_q;
   assign apple_y_d = latch_en ? appleY : apple_y_q;
   assign snake_x_d = latch_en ? snakeX : snake_x_q;
   assign snake_y_d = latch_en ? snakeY : snake_y_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= RST_LOW;
         cnt_q      <= '0;
         step_q     <= '0;
         slp_wait_q <= 1'b0;
         reset_n_q  <= 1'b0;
         lcd_on_q   <= 1'b0;
         px_q       <= '0;
         py_q       <= '0;
         col_q      <= '0;
         apple_x_q  <= '0;
         apple_y_q  <= '0;
         snake_x_q  <= '0;
         snake_y_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         step_q     <= step_d;
         slp_wait_q <= slp_wait_d;
         reset_n_q  <= reset_n_d;
         lcd_on_q   <= lcd_on_d;
         px_q       <= px_d;
         py_q       <= py_d;
         col_q      <= col_d;
         apple_x_q  <= apple_x_d;
         apple_y_q  <= apple_y_d;
         snake_x_q  <= snake_x_d;
         snake_y_q  <= snake_y_d;
      end
   end

   lt24_word_writer u_writer (
      .clock (clock),
      .reset (reset),
      .valid (wr_valid),
      .word  (wr_word),
      .ready (wr_ready),
      .wr_n  (lcd.LT24Wr_n),
      .cs_n  (lcd.LT24CS_n),
      .rs    (lcd.LT24RS),
      .data  (lcd.LT24Data)
   );

   assign lcd.LT24Rd_n    = 1'b1;
   assign lcd.LT24Reset_n = reset_n_q;
   assign lcd.LT24LCDOn   = lcd_on_q;

endmodule

// File: tb/tb_screen_writer.sv
// Scoreboard bench for screen_writer on a shortened panel (240x20) with a short settle wait,
// so several complete frames fit in a modest simulation.
module tb_screen_writer;

   localparam int NSEG     = 128;
   localparam int BLOCK    = 10;
   localparam int H_RES    = 240;
   localparam int V_RES    = 20;
   localparam int RST_LOW  = 500;
   localparam int RST_WAIT = 40;
   localparam int NPIX     = H_RES * V_RES;

   localparam logic [15:0] RED    = 16'hF800;
   localparam logic [15:0] YELLOW = 16'hFFE0;
   localparam logic [15:0] GREEN  = 16'h07E0;
   localparam logic [15:0] BLACK  = 16'h0000;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic [7:0]        apple_x;
   logic [8:0]        apple_y;
   logic [8*NSEG-1:0] snake_x;
   logic [9*NSEG-1:0] snake_y;

   screen_writer_if lcd ();

   screen_writer #(
      .RST_WAIT_CYCLES (RST_WAIT),
      .H_RES           (H_RES),
      .V_RES           (V_RES)
   ) dut (
      .clock  (clock),
      .reset  (reset),
      .appleX (apple_x),
      .appleY (apple_y),
      .snakeX (snake_x),
      .snakeY (snake_y),
      .lcd    (lcd)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int          idx;
      logic [15:0] col;
      string       name;
   } pix_exp_t;

   logic [16:0] obs_q[$];
   logic [16:0] exp_word[$];
   pix_exp_t    exp_pix[$];

   int drv_ax, drv_ay;
   int drv_sx[NSEG];
   int drv_sy[NSEG];
   int mdl_ax, mdl_ay;
   int mdl_sx[NSEG];
   int mdl_sy[NSEG];

   // Every write strobe seen on the bus is logged as {RS, data}.
   always @(negedge clock) begin
      if (lcd.LT24CS_n === 1'b0 && lcd.LT24Wr_n === 1'b0)
         obs_q.push_back({lcd.LT24RS, lcd.LT24Data});
   end

   // Watchdog so a stuck design still ends the run.
   initial begin
      #800_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic drive_scene();
      apple_x = 8'(drv_ax);
      apple_y = 9'(drv_ay);
      for (int i = 0; i < NSEG; i++) begin
         snake_x[8*i +: 8] = 8'(drv_sx[i]);
         snake_y[9*i +: 9] = 9'(drv_sy[i]);
      end
   endtask

   task automatic clear_snake();
      for (int i = 0; i < NSEG; i++) begin
         drv_sx[i] = 0;
         drv_sy[i] = 0;
      end
   endtask

   task automatic scene_a();
      clear_snake();
      drv_ax = 120; drv_ay = 2;
      drv_sx[0] = 40; drv_sy[0] = 8;
      drv_sx[1] = 50; drv_sy[1] = 8;
      drv_sx[2] = 60; drv_sy[2] = 8;
      drive_scene();
   endtask

   task automatic scene_b();
      clear_snake();
      drv_ax = 120; drv_ay = 2;
      drv_sx[0] = 30; drv_sy[0] = 8;
      drv_sx[1] = 40; drv_sy[1] = 8;
      drv_sx[2] = 50; drv_sy[2] = 8;
      drive_scene();
   endtask

   task automatic scene_c();
      clear_snake();
      drv_ax = 230; drv_ay = 15;
      drv_sx[0] = 230; drv_sy[0] = 15;
      drv_sx[NSEG-1] = 10; drv_sy[NSEG-1] = 5;
      drive_scene();
   endtask

   function automatic bit model_in(int x, int y, int bx, int by);
      return (x >= bx) && (x < bx + BLOCK) && (y >= by) && (y < by + BLOCK);
   endfunction

   // Reference colour for the coordinates latched at the start of the frame.
   function automatic logic [15:0] model_col(int x, int y);
      bit body;
      body = 1'b0;
      if (model_in(x, y, mdl_ax, mdl_ay)) return RED;
      if ((mdl_sx[0] != 0 || mdl_sy[0] != 0) && model_in(x, y, mdl_sx[0], mdl_sy[0])) return YELLOW;
      for (int i = 0; i < NSEG; i++)
         if ((mdl_sx[i] != 0 || mdl_sy[i] != 0) && model_in(x, y, mdl_sx[i], mdl_sy[i])) body = 1'b1;
      return body ? GREEN : BLACK;
   endfunction

   task automatic get_word(output logic [16:0] w, output bit ok);
      int n;
      n  = 0;
      w  = '0;
      ok = 1'b0;
      while (obs_q.size() == 0 && n < 5000) begin
         @(posedge clock);
         n++;
      end
      if (obs_q.size() != 0) begin
         w  = obs_q.pop_front();
         ok = 1'b1;
      end
   endtask

   function automatic void push_pix(int x, int y, logic [15:0] col, string name);
      pix_exp_t e;
      e.idx  = y * H_RES + x;
      e.col  = col;
      e.name = name;
      exp_pix.push_back(e);
   endfunction

   // Consumes one pixel burst plus the following window setup, checking scoreboard entries
   // and the whole frame against the reference model; optionally swaps the scene mid-frame.
   task automatic run_frame(input string tag, input int upd_idx, input int upd_scene);
      logic [16:0] w;
      logic [15:0] ref_col;
      bit          ok;
      int          n_pix, mism, first_bad;
      pix_exp_t    e;
      mdl_ax = drv_ax;
      mdl_ay = drv_ay;
      for (int i = 0; i < NSEG; i++) begin
         mdl_sx[i] = drv_sx[i];
         mdl_sy[i] = drv_sy[i];
      end
      n_pix = 0; mism = 0; first_bad = -1; ok = 1'b1; w = '0;
      for (int guard = 0; guard < NPIX + 16; guard++) begin
         get_word(w, ok);
         if (!ok || w[16] !== 1'b1) break;
         if (exp_pix.size() > 0 && exp_pix[0].idx == n_pix) begin
            e = exp_pix.pop_front();
            n_checks++;
            if (w[15:0] !== e.col) begin
               n_fail++;
               $display("[TB] FAIL %s %s: got %h expected %h", tag, e.name, w[15:0], e.col);
            end
         end
         ref_col = model_col(n_pix % H_RES, n_pix / H_RES);
         if (w[15:0] !== ref_col) begin
            if (first_bad < 0) first_bad = n_pix;
            mism++;
         end
         n_pix++;
         if (n_pix == upd_idx) begin
            if (upd_scene == 1) scene_b();
            else if (upd_scene == 2) scene_c();
         end
      end
      n_checks++;
      if (!ok || n_pix != NPIX) begin
         n_fail++;
         $display("[TB] FAIL %s pixel_count: got %0d expected %0d (bus ok=%0d)", tag, n_pix, NPIX, ok);
      end
      n_checks++;
      if (mism != 0) begin
         n_fail++;
         $display("[TB] FAIL %s frame_model: got %0d mismatching pixels (first index %0d) expected 0", tag, mism, first_bad);
      end
      n_checks++;
      if (exp_pix.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL %s unchecked_points: got %0d left expected 0", tag, exp_pix.size());
         exp_pix.delete();
      end
      n_checks++;
      if (!ok || w !== {1'b0, 16'h002A}) begin
         n_fail++;
         $display("[TB] FAIL %s next_caset: got %h expected %h", tag, w, {1'b0, 16'h002A});
      end
      for (int i = 0; i < 10; i++) get_word(w, ok);
      n_checks++;
      if (!ok || w !== {1'b0, 16'h002C}) begin
         n_fail++;
         $display("[TB] FAIL %s next_ramwr: got %h expected %h", tag, w, {1'b0, 16'h002C});
      end
   endtask

   task automatic test_reset_release(input string tag);
      int n;
      n = 0;
      while (lcd.LT24Reset_n !== 1'b1 && n < 2000) begin
         @(posedge clock);
         #1;
         n++;
      end
      n_checks++;
      if (n != RST_LOW) begin
         n_fail++;
         $display("[TB] FAIL %s reset_low_len: got %0d cycles expected %0d", tag, n, RST_LOW);
      end
      n_checks++;
      if (lcd.LT24LCDOn !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL %s lcd_on: got %b expected 1", tag, lcd.LT24LCDOn);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (10) @(posedge clock);
      #1;
      n_checks++;
      if (lcd.LT24Reset_n !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_reset_n: got %b expected 0", lcd.LT24Reset_n); end
      n_checks++;
      if (lcd.LT24CS_n !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_cs_n: got %b expected 1", lcd.LT24CS_n); end
      n_checks++;
      if (lcd.LT24Wr_n !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_wr_n: got %b expected 1", lcd.LT24Wr_n); end
      n_checks++;
      if (lcd.LT24LCDOn !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_lcd_on: got %b expected 0", lcd.LT24LCDOn); end
      n_checks++;
      if (lcd.LT24Rd_n !== 1'b1 || lcd.LT24RS !== 1'b1 || lcd.LT24Data !== 16'h0000) begin
         n_fail++;
         $display("[TB] FAIL rst_rd_rs_data: got %b/%b/%h expected 1/1/0000", lcd.LT24Rd_n, lcd.LT24RS, lcd.LT24Data);
      end
      @(negedge clock);
      reset = 1'b0;
      test_reset_release("power_up");
   endtask

   task automatic test_init(input string tag);
      logic [16:0] w, e;
      bit          ok;
      int          k;
      exp_word.push_back({1'b0, 16'h0011});
      exp_word.push_back({1'b0, 16'h003A});
      exp_word.push_back({1'b1, 16'h0055});
      exp_word.push_back({1'b0, 16'h0036});
      exp_word.push_back({1'b1, 16'h0008});
      exp_word.push_back({1'b0, 16'h0029});
      exp_word.push_back({1'b0, 16'h002A});
      exp_word.push_back({1'b1, 16'h0000});
      exp_word.push_back({1'b1, 16'h0000});
      exp_word.push_back({1'b1, 16'((H_RES - 1) >> 8)});
      exp_word.push_back({1'b1, 16'((H_RES - 1) & 255)});
      exp_word.push_back({1'b0, 16'h002B});
      exp_word.push_back({1'b1, 16'h0000});
      exp_word.push_back({1'b1, 16'h0000});
      exp_word.push_back({1'b1, 16'((V_RES - 1) >> 8)});
      exp_word.push_back({1'b1, 16'((V_RES - 1) & 255)});
      exp_word.push_back({1'b0, 16'h002C});
      k = 0;
      while (exp_word.size() > 0) begin
         e = exp_word.pop_front();
         get_word(w, ok);
         n_checks++;
         if (!ok || w !== e) begin
            n_fail++;
            $display("[TB] FAIL %s init_word[%0d]: got %h expected %h (bus ok=%0d)", tag, k, w, e, ok);
         end
         k++;
      end
   endtask

   task automatic test_frame_basic();
      push_pix(0,   0,  BLACK,  "origin_bg");
      push_pix(120, 2,  RED,    "apple_corner");
      push_pix(130, 2,  BLACK,  "apple_right_of");
      push_pix(55,  8,  GREEN,  "body_seg1");
      push_pix(70,  8,  BLACK,  "past_tail");
      push_pix(129, 11, RED,    "apple_far_corner");
      push_pix(45,  13, YELLOW, "head_inside");
      push_pix(69,  17, GREEN,  "tail_far_corner");
      run_frame("frame1", -1, 0);
   endtask

   task automatic test_midframe_update();
      push_pix(35, 8, BLACK, "old_scene_left");
      push_pix(60, 8, GREEN, "old_scene_tail");
      run_frame("frame2", 100, 1);
      push_pix(35, 8, YELLOW, "new_head");
      push_pix(45, 8, GREEN,  "new_body");
      push_pix(60, 8, BLACK,  "old_tail_gone");
      run_frame("frame3", 100, 2);
   endtask

   task automatic test_overlap_edge();
      push_pix(0,   0,  BLACK, "no_wrap_origin");
      push_pix(120, 2,  BLACK, "old_apple_gone");
      push_pix(10,  5,  GREEN, "last_slot_corner");
      push_pix(15,  14, GREEN, "last_slot_far");
      push_pix(229, 15, BLACK, "left_of_overlap");
      push_pix(235, 18, RED,   "apple_over_head");
      push_pix(239, 19, RED,   "clipped_corner");
      run_frame("frame4", -1, 0);
   endtask

   task automatic test_reset_midframe();
      logic [16:0] w;
      bit          ok;
      for (int i = 0; i < 50; i++) get_word(w, ok);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      n_checks++;
      if (lcd.LT24Reset_n !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_reset_n: got %b expected 0", lcd.LT24Reset_n); end
      n_checks++;
      if (lcd.LT24CS_n !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_cs_n: got %b expected 1", lcd.LT24CS_n); end
      n_checks++;
      if (lcd.LT24LCDOn !== 1'b0 || lcd.LT24Wr_n !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL midrst_lcdon_wr: got %b/%b expected 0/1", lcd.LT24LCDOn, lcd.LT24Wr_n);
      end
      repeat (2) @(posedge clock);
      @(negedge clock);
      obs_q.delete();
      reset = 1'b0;
      test_reset_release("mid_frame");
      test_init("replay");
   endtask

   initial begin
      snake_x = '0;
      snake_y = '0;
      scene_a();
      test_reset();
      test_init("power_up");
      test_frame_basic();
      test_midframe_update();
      test_overlap_edge();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
